// File: rtl/fwd_pkg.sv
// Shared types and helpers for the branch operand forwarding unit.
//   reg_idx_t    : architectural register index
//   pend_entry_t : one in-flight divider write {valid, rd}
//   fwd_match    : true when a writer with enable `we` targets a
//                  non-zero register equal to `addr`
package fwd_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } pend_entry_t;

  // x0 is hard-wired to zero, so it never matches a writer.
  function automatic logic fwd_match(reg_idx_t addr, reg_idx_t rd, logic we);
    return we && (rd == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/pend_fifo.sv
// Ordered tag FIFO of in-flight divider destinations.
// Divides retire in issue order: push at tail, pop at head.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   push, push_rd         : enqueue a destination (rd==0 is ignored)
//   pop                   : retire the head entry (ignored when empty)
//   flush                 : drop every entry; beats push/pop
//   q_addr                : NQ lookup addresses, 5 bits each
//   q_hit                 : lookup matches any valid entry
//   q_head_sole           : lookup matches the head and no younger entry
//   count, full           : occupancy
module pend_fifo
  import fwd_pkg::*;
#(
  parameter int NPEND = 4,
  parameter int NQ    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [4:0]                 push_rd,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [NQ*5-1:0]            q_addr,
  output logic [NQ-1:0]              q_hit,
  output logic [NQ-1:0]              q_head_sole,
  output logic [$clog2(NPEND):0]     count,
  output logic                       full
);

  localparam int PW = $clog2(NPEND);
  localparam int CW = PW + 1;

  pend_entry_t [NPEND-1:0] ent_q, ent_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    push_ok, pop_ok;

  assign full  = (count_q == CW'(NPEND));
  assign count = count_q;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head retires the same cycle.
    push_ok = push && (push_rd != '0) && (!full || pop_ok);
    if (flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pop before push: when full, head==tail and the slot is reused.
      if (pop_ok) begin
        ent_d[head_q].valid = 1'b0;
        head_d              = head_q + 1'b1;
      end
      if (push_ok) begin
        ent_d[tail_q].valid = 1'b1;
        ent_d[tail_q].rd    = push_rd;
        tail_d              = tail_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Per-lookup match vector; every valid entry other than the head is
  // younger than the head, so masking the head bit yields the younger set.
  for (genvar j = 0; j < NQ; j++) begin : g_q
    logic [NPEND-1:0] match;
    logic [NPEND-1:0] younger;
    always_comb begin
      match = '0;
      for (int e = 0; e < NPEND; e++) begin
        match[e] = fwd_match(q_addr[j*5 +: 5], ent_q[e].rd, ent_q[e].valid);
      end
    end
    assign younger        = match & ~(NPEND'(1) << head_q);
    assign q_hit[j]       = |match;
    assign q_head_sole[j] = match[head_q] && (younger == '0);
  end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// Decode-stage operand forwarding for branch compare / early resolve,
// with a scoreboard of in-flight multi-cycle divides.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   id_rs_addr/id_rs_data           : NREAD decode operands and RF data
//   id_rd/id_regwrite               : decode destination (WAW check)
//   src_rd/src_regwrite/src_memread/src_data : NSRC pipeline taps, 0 youngest
//   div_issue/div_rd                : divide leaving ID
//   div_done/div_res                : oldest pending divide completes
//   flush                           : abort all pending divides
//   id_rs_mod                       : forwarded operands
//   id_stall                        : hold ID/IF
//   div_issue_ok                    : scoreboard can take a divide
//   pend_count                      : pending divide count (registered)
//
// Divide handshake: a divide is accepted on a clk edge where
// div_issue && div_issue_ok (and no flush). div_issue_ok does not depend
// on div_issue, so the issuer may look at it before asserting div_issue.
// Issuing while !div_issue_ok drops the divide and raises id_stall.
module branch_fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int NSRC  = 2,
  parameter int NPEND = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREAD*5-1:0]         id_rs_addr,
  input  logic [NREAD*XLEN-1:0]      id_rs_data,
  input  logic [4:0]                 id_rd,
  input  logic                       id_regwrite,
  input  logic [NSRC*5-1:0]          src_rd,
  input  logic [NSRC-1:0]            src_regwrite,
  input  logic [NSRC-1:0]            src_memread,
  input  logic [NSRC*XLEN-1:0]       src_data,
  input  logic                       div_issue,
  input  logic [4:0]                 div_rd,
  input  logic                       div_done,
  input  logic [XLEN-1:0]            div_res,
  input  logic                       flush,
  output logic [NREAD*XLEN-1:0]      id_rs_mod,
  output logic                       id_stall,
  output logic                       div_issue_ok,
  output logic [$clog2(NPEND):0]     pend_count
);

  localparam int NQ = NREAD + 1;  // one lookup per operand plus id_rd

  logic [NQ-1:0]    q_hit;
  logic [NQ-1:0]    q_head_sole;
  logic             full;
  logic [NREAD-1:0] op_stall_vec;
  logic             waw_stall;
  logic             struct_stall;

  pend_fifo #(
    .NPEND (NPEND),
    .NQ    (NQ)
  ) u_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (div_issue),
    .push_rd     (div_rd),
    .pop         (div_done),
    .flush       (flush),
    .q_addr      ({id_rd, id_rs_addr}),
    .q_hit       (q_hit),
    .q_head_sole (q_head_sole),
    .count       (pend_count),
    .full        (full)
  );

  assign div_issue_ok = !full || div_done;

  // Per-operand priority mux: x0, then youngest pipeline source, then
  // scoreboard (bypass the retiring divide only if it is the sole match),
  // then register file.
  for (genvar i = 0; i < NREAD; i++) begin : g_op
    logic [4:0]      addr;
    logic [XLEN-1:0] op_mod;
    logic            op_stall;
    logic            found;
    assign addr = id_rs_addr[i*5 +: 5];
    always_comb begin
      op_mod   = id_rs_data[i*XLEN +: XLEN];
      op_stall = 1'b0;
      found    = 1'b0;
      if (addr == '0) begin
        op_mod = '0;
      end else begin
        for (int k = 0; k < NSRC; k++) begin
          if (!found && fwd_match(addr, src_rd[k*5 +: 5], src_regwrite[k])) begin
            found = 1'b1;
            if (src_memread[k]) op_stall = 1'b1;
            else                op_mod   = src_data[k*XLEN +: XLEN];
          end
        end
        if (!found && q_hit[i]) begin
          if (div_done && q_head_sole[i]) op_mod   = div_res;
          else                            op_stall = 1'b1;
        end
      end
    end
    assign id_rs_mod[i*XLEN +: XLEN] = op_mod;
    assign op_stall_vec[i]           = op_stall;
  end

  // A write to a register that a divide will still write later would be
  // overtaken by the divide result; the retiring head entry is harmless.
  assign waw_stall = id_regwrite && (id_rd != '0) && q_hit[NREAD]
                     && !(div_done && q_head_sole[NREAD]);

  assign struct_stall = div_issue && !div_issue_ok;

  assign id_stall = !flush && ((|op_stall_vec) || waw_stall || struct_stall);

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(div_issue && !div_issue_ok));
    end
  end

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Bench for branch_fwd_scoreboard: directed steps from the test plan,
// then randomized cycles, all checked against a queue-based model.
module tb_branch_fwd_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREAD = 2;
  localparam int NSRC  = 2;
  localparam int NPEND = 4;
  localparam int CW    = $clog2(NPEND) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREAD*5-1:0]    id_rs_addr;
  logic [NREAD*XLEN-1:0] id_rs_data;
  logic [4:0]            id_rd;
  logic                  id_regwrite;
  logic [NSRC*5-1:0]     src_rd;
  logic [NSRC-1:0]       src_regwrite;
  logic [NSRC-1:0]       src_memread;
  logic [NSRC*XLEN-1:0]  src_data;
  logic                  div_issue;
  logic [4:0]            div_rd;
  logic                  div_done;
  logic [XLEN-1:0]       div_res;
  logic                  flush;
  logic [NREAD*XLEN-1:0] id_rs_mod;
  logic                  id_stall;
  logic                  div_issue_ok;
  logic [CW-1:0]         pend_count;

  branch_fwd_scoreboard #(
    .XLEN (XLEN), .NREAD (NREAD), .NSRC (NSRC), .NPEND (NPEND)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs_addr   (id_rs_addr),
    .id_rs_data   (id_rs_data),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .src_rd       (src_rd),
    .src_regwrite (src_regwrite),
    .src_memread  (src_memread),
    .src_data     (src_data),
    .div_issue    (div_issue),
    .div_rd       (div_rd),
    .div_done     (div_done),
    .div_res      (div_res),
    .flush        (flush),
    .id_rs_mod    (id_rs_mod),
    .id_stall     (id_stall),
    .div_issue_ok (div_issue_ok),
    .pend_count   (pend_count)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  int unsigned           pend_m[$];   // destinations of pending divides, oldest first
  logic [NREAD*XLEN-1:0] exp_q[$];    // expected operand vectors

  // Values observed at the last sampling point, for directed literal checks.
  logic [NREAD*XLEN-1:0] obs_mod;
  logic                  obs_stall;
  logic                  obs_ok;
  logic [CW-1:0]         obs_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_eval(output logic [NREAD*XLEN-1:0] mod,
                                     output logic stall, output logic ok);
    int unsigned     n;
    int unsigned     a;
    int              hits;
    bit              found;
    logic [XLEN-1:0] v;
    n     = pend_m.size();
    ok    = (n < NPEND) || div_done;
    stall = 1'b0;
    mod   = '0;
    for (int i = 0; i < NREAD; i++) begin
      a     = id_rs_addr[i*5 +: 5];
      v     = id_rs_data[i*XLEN +: XLEN];
      found = 0;
      hits  = 0;
      if (a == 0) v = '0;
      else begin
        for (int k = 0; k < NSRC; k++) begin
          if (!found && src_regwrite[k] && src_rd[k*5 +: 5] == a) begin
            found = 1;
            if (src_memread[k]) stall = 1'b1;
            else v = src_data[k*XLEN +: XLEN];
          end
        end
        if (!found) begin
          foreach (pend_m[e]) if (pend_m[e] == a) hits++;
          if (hits > 0) begin
            if (div_done && pend_m[0] == a && hits == 1) v = div_res;
            else stall = 1'b1;
          end
        end
      end
      mod[i*XLEN +: XLEN] = v;
    end
    if (id_regwrite && id_rd != 0) begin
      for (int e = ((div_done && n > 0) ? 1 : 0); e < int'(n); e++)
        if (pend_m[e] == id_rd) stall = 1'b1;
    end
    if (div_issue && !ok) stall = 1'b1;
    if (flush) stall = 1'b0;
  endfunction

  function automatic void model_update();
    int unsigned n;
    bit ok;
    n  = pend_m.size();
    ok = (n < NPEND) || div_done;
    if (!rst_n || flush) pend_m.delete();
    else begin
      if (div_done && n > 0) void'(pend_m.pop_front());
      if (div_issue && ok && div_rd != 0) pend_m.push_back(div_rd);
    end
  endfunction

  // One cycle: sample on the falling edge, then let the clock edge happen.
  task automatic step(input string tag);
    logic [NREAD*XLEN-1:0] emod;
    logic estall, eok;
    @(negedge clk);
    model_eval(emod, estall, eok);
    exp_q.push_back(emod);
    obs_mod = id_rs_mod; obs_stall = id_stall; obs_ok = div_issue_ok; obs_pc = pend_count;
    chk({tag, ".mod"},   64'(id_rs_mod),    64'(exp_q.pop_front()));
    chk({tag, ".stall"}, 64'(id_stall),     64'(estall));
    chk({tag, ".ok"},    64'(div_issue_ok), 64'(eok));
    @(posedge clk);
    model_update();
    #1;
    chk({tag, ".pc"}, 64'(pend_count), 64'(pend_m.size()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs_addr = '0; id_rs_data = '0; id_rd = '0; id_regwrite = 1'b0;
    src_rd = '0; src_regwrite = '0; src_memread = '0; src_data = '0;
    div_issue = 1'b0; div_rd = '0; div_done = 1'b0; div_res = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    clear_inputs();
    div_issue = 1'b1; div_rd = rd;
    step("issue");
  endtask

  task automatic random_inputs();
    bit ok_m;
    rst_n        = ($urandom_range(0, 99) != 0);
    flush        = ($urandom_range(0, 39) == 0);
    id_rd        = 5'($urandom_range(0, 7));
    id_regwrite  = 1'($urandom_range(0, 1));
    src_regwrite = NSRC'($urandom);
    src_memread  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
    for (int i = 0; i < NREAD; i++) begin
      id_rs_addr[i*5 +: 5]       = 5'($urandom_range(0, 7));
      id_rs_data[i*XLEN +: XLEN] = $urandom;
    end
    for (int k = 0; k < NSRC; k++) begin
      src_rd[k*5 +: 5]         = 5'($urandom_range(0, 7));
      src_data[k*XLEN +: XLEN] = $urandom;
    end
    div_done  = ($urandom_range(0, 2) == 0);
    div_res   = $urandom;
    div_rd    = 5'($urandom_range(0, 7));
    ok_m      = (pend_m.size() < NPEND) || div_done;
    div_issue = ($urandom_range(0, 1) == 1) && ok_m;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step("rst0");
    step("rst1");
    chk("rst.pc",    64'(obs_pc),    64'd0);
    chk("rst.ok",    64'(obs_ok),    64'd1);
    chk("rst.stall", 64'(obs_stall), 64'd0);
    rst_n = 1'b1;

    // Two operands from two different sources.
    clear_inputs();
    id_rs_addr = {5'd5, 5'd3}; id_rs_data = {32'hFFFF_0001, 32'hFFFF_0002};
    src_rd = {5'd3, 5'd5}; src_regwrite = 2'b11;
    src_data = {32'h0000_1234, 32'hAAAA_0000};
    step("fwd2");
    chk("fwd2.lit", 64'(obs_mod), 64'hAAAA0000_00001234);
    chk("fwd2.nostall", 64'(obs_stall), 64'd0);

    // Youngest source wins, then a load hazard, then x0.
    src_rd = {5'd7, 5'd7}; src_data = {32'h22, 32'h11}; id_rs_addr = {5'd7, 5'd7};
    step("young");
    chk("young.lit", 64'(obs_mod), 64'h00000011_00000011);
    src_memread = 2'b01;
    step("load");
    chk("load.lit", 64'(obs_stall), 64'd1);
    id_rs_addr = '0; src_rd = '0; src_memread = 2'b11;
    step("x0");
    chk("x0.lit", 64'(obs_mod), 64'd0);
    chk("x0.nostall", 64'(obs_stall), 64'd0);

    // Single divide: stall, bypass on completion, drain.
    issue(5'd9);
    clear_inputs(); id_rs_addr = {5'd0, 5'd9};
    step("div_raw");
    chk("div_raw.lit", 64'(obs_stall), 64'd1);
    chk("div_raw.pc",  64'(obs_pc),    64'd1);
    div_done = 1'b1; div_res = 32'hDEAD;
    step("div_byp");
    chk("div_byp.lit", 64'(obs_mod[XLEN-1:0]), 64'hDEAD);
    chk("div_byp.nostall", 64'(obs_stall), 64'd0);
    clear_inputs();
    step("div_drain");
    chk("div_drain.pc", 64'(obs_pc), 64'd0);

    // Fill, then issue with a same-cycle completion while full.
    for (int r = 1; r <= NPEND; r++) issue(5'(r));
    clear_inputs();
    step("full");
    chk("full.ok", 64'(obs_ok), 64'd0);
    chk("full.pc", 64'(obs_pc), 64'd4);
    div_issue = 1'b1; div_rd = 5'd5; div_done = 1'b1;
    step("full_swap");
    clear_inputs(); id_rs_addr = {5'd0, 5'd5};
    step("full_tail");
    chk("full_tail.pc",    64'(obs_pc),    64'd4);
    chk("full_tail.stall", 64'(obs_stall), 64'd1);
    clear_inputs(); div_done = 1'b1;
    for (int r = 0; r < NPEND; r++) step("drain");

    // Duplicate pending destination and WAW.
    issue(5'd6);
    issue(5'd6);
    clear_inputs(); id_rs_addr = {5'd0, 5'd6}; div_done = 1'b1; div_res = 32'hBEEF;
    step("dup");
    chk("dup.lit", 64'(obs_stall), 64'd1);
    clear_inputs(); id_regwrite = 1'b1; id_rd = 5'd6;
    step("waw");
    chk("waw.lit", 64'(obs_stall), 64'd1);

    // Flush beats a same-cycle issue; later done is ignored.
    issue(5'd10);
    issue(5'd11);
    clear_inputs(); flush = 1'b1; div_issue = 1'b1; div_rd = 5'd12;
    step("flush");
    clear_inputs(); id_rs_addr = {5'd10, 5'd6};
    step("post_flush");
    chk("post_flush.pc",    64'(obs_pc),    64'd0);
    chk("post_flush.stall", 64'(obs_stall), 64'd0);
    div_done = 1'b1;
    step("stray_done");
    clear_inputs();
    step("stray_after");
    chk("stray_after.pc", 64'(obs_pc), 64'd0);

    // Reset mid-operation.
    issue(5'd13); issue(5'd14); issue(5'd15);
    clear_inputs(); rst_n = 1'b0;
    step("mid_rst");
    rst_n = 1'b1; id_rs_addr = {5'd14, 5'd13};
    step("after_rst");
    chk("after_rst.pc",    64'(obs_pc),    64'd0);
    chk("after_rst.stall", 64'(obs_stall), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      random_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
